// File: rtl/inst_fetch.sv
// inst_fetch: in-order instruction fetch with a small prefetch buffer.
// Redirects flush the buffer and silently drop old-stream responses.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst_data,
  output logic [31:0] o_inst_pc
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int DW = CW + 2;
  localparam int SW = DW + 1;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
  localparam logic [SW-1:0] DMAX_S  = SW'((1 << DW) - 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] live_q, live_d;
  logic [DW-1:0] disc_q, disc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   pc_d   [DEPTH];

  logic run, req, hs;
  logic rsp_disc, rsp_live;
  logic push, pop;

  assign run = (state_q == S_RUN);

  // Discard backlog is capped so the discard counter can never wrap.
  assign req = run
    && ((SW'(live_q) + SW'(count_q)) < DEPTH_S)
    && ((SW'(disc_q) + SW'(live_q)) < DMAX_S);
  assign hs = req && i_imem_ack;

  assign rsp_disc = run && i_imem_rvalid
    && (disc_q != '0);
  assign rsp_live = run && i_imem_rvalid
    && (disc_q == '0) && (live_q != '0);

  assign push = rsp_live && !i_redirect;
  assign pop  = run && (count_q != '0)
    && !i_stall && !i_redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    live_d     = live_q;
    disc_d     = disc_q;
    count_d    = count_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    data_d     = data_q;
    pc_d       = pc_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_RUN;
      end
      S_RUN: begin
        if (i_redirect) begin
          fetch_pc_d = i_redirect_pc;
          resp_pc_d  = i_redirect_pc;
          live_d     = '0;
          // Everything still live, plus this cycle's request, is old.
          disc_d     = disc_q + DW'(live_q) + DW'(hs)
                     - DW'(rsp_disc) - DW'(rsp_live);
          count_d    = '0;
          wr_d       = '0;
          rd_d       = '0;
        end else begin
          fetch_pc_d = fetch_pc_q + 32'(hs);
          live_d     = live_q + CW'(hs) - CW'(rsp_live);
          disc_d     = disc_q - DW'(rsp_disc);
          count_d    = count_q + CW'(push) - CW'(pop);
          if (push) begin
            data_d[wr_q] = i_imem_rdata;
            pc_d[wr_q]   = resp_pc_q;
            wr_d         = wr_q + PW'(1);
            resp_pc_d    = resp_pc_q + 32'd1;
          end
          if (pop) rd_d = rd_q + PW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      live_q     <= '0;
      disc_q     <= '0;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      live_q     <= live_d;
      disc_q     <= disc_d;
      count_q    <= count_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
    end
  end

  assign o_imem_req   = req;
  assign o_imem_addr  = fetch_pc_q;
  assign o_inst_valid = (count_q != '0);
  assign o_inst_data  = o_inst_valid ? data_q[rd_q] : NOP_INST;
  assign o_inst_pc    = o_inst_valid ? pc_q[rd_q] : 32'h0;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed vector table on a DEPTH=2 fetch unit plus
// zero-wait and randomised-latency scoreboard runs on a DEPTH=4 unit.
module tb_inst_fetch;
  localparam logic [31:0] N = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_start, a_stall, a_redir, a_ack, a_rv;
  logic [31:0] a_rpc, a_rdata;
  logic        a_req, a_valid;
  logic [31:0] a_addr, a_data, a_pc;

  logic        b_start, b_stall, b_redir, b_ack, b_rv;
  logic [31:0] b_rpc, b_rdata;
  logic        b_req, b_valid;
  logic [31:0] b_addr, b_data, b_pc;

  inst_fetch #(.RESET_PC(32'h0), .DEPTH(2), .NOP_INST(N)) dut2 (
    .i_clk(clk), .i_rst(rst),
    .i_start(a_start), .i_stall(a_stall),
    .i_redirect(a_redir), .i_redirect_pc(a_rpc),
    .o_imem_req(a_req), .o_imem_addr(a_addr),
    .i_imem_ack(a_ack), .i_imem_rvalid(a_rv),
    .i_imem_rdata(a_rdata),
    .o_inst_valid(a_valid), .o_inst_data(a_data),
    .o_inst_pc(a_pc)
  );

  inst_fetch #(.RESET_PC(32'h0), .DEPTH(4), .NOP_INST(N)) dut4 (
    .i_clk(clk), .i_rst(rst),
    .i_start(b_start), .i_stall(b_stall),
    .i_redirect(b_redir), .i_redirect_pc(b_rpc),
    .o_imem_req(b_req), .o_imem_addr(b_addr),
    .i_imem_ack(b_ack), .i_imem_rvalid(b_rv),
    .i_imem_rdata(b_rdata),
    .o_inst_valid(b_valid), .o_inst_data(b_data),
    .o_inst_pc(b_pc)
  );

  typedef struct {
    logic        start, stall, redir;
    logic [31:0] rpc;
    logic        ack, rv;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] data;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];
  int passed = 0;
  int total  = 0;

  logic [31:0] mq_addr[$];
  int          mq_age[$];
  int          mq_dly[$];
  logic [31:0] exp_pc;
  int          pops;

  function automatic logic [31:0] dimg(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  function automatic logic [31:0] img(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic vec_t mk(
    input logic st, input logic sl, input logic rd,
    input logic [31:0] rpc, input logic ack, input logic rv,
    input logic [31:0] rdata, input logic req,
    input logic [31:0] addr, input logic v,
    input logic [31:0] data, input logic [31:0] pc);
    vec_t t;
    t.start = st; t.stall = sl; t.redir = rd; t.rpc = rpc;
    t.ack = ack; t.rv = rv; t.rdata = rdata;
    t.req = req; t.addr = addr; t.valid = v;
    t.data = data; t.pc = pc;
    return t;
  endfunction

  task automatic chk(input string nm,
                     input logic [97:0] act,
                     input logic [97:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic step4(input bit rnd, input bit st, input int want_v);
    bit          hs, rv, rdr;
    logic [31:0] hsa, rpc;
    @(negedge clk);
    b_start = st;
    b_stall = rnd && ($urandom_range(0, 3) == 0);
    rdr     = rnd && ($urandom_range(0, 24) == 0);
    rpc     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
    b_redir = rdr;
    b_rpc   = rpc;
    b_ack   = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    rv      = (mq_addr.size() > 0) && (mq_age[0] >= mq_dly[0]);
    b_rv    = rv;
    b_rdata = rv ? img(mq_addr[0]) : $urandom;
    #1;
    if (want_v >= 0)
      chk("zw_valid", 98'(b_valid), 98'(want_v[0]));
    if (b_valid && !b_stall && !rdr) begin
      chk("seq_pc", 98'(b_pc), 98'(exp_pc));
      chk("seq_data", 98'(b_data), 98'(img(exp_pc)));
      exp_pc = exp_pc + 32'd1;
      pops++;
    end
    hs  = b_req && b_ack;
    hsa = b_addr;
    @(posedge clk);
    if (rv) begin
      void'(mq_addr.pop_front());
      void'(mq_age.pop_front());
      void'(mq_dly.pop_front());
    end
    foreach (mq_age[i]) mq_age[i]++;
    if (hs) begin
      mq_addr.push_back(hsa);
      mq_age.push_back(0);
      mq_dly.push_back(rnd ? $urandom_range(0, 4) : 0);
    end
    if (rdr) exp_pc = rpc;
  endtask

  initial begin
    a_start = 0; a_stall = 0; a_redir = 0; a_rpc = 0;
    a_ack = 0; a_rv = 0; a_rdata = 0;
    b_start = 0; b_stall = 0; b_redir = 0; b_rpc = 0;
    b_ack = 0; b_rv = 0; b_rdata = 0;
    exp_pc = 0; pops = 0;

    vecs.push_back(mk(0,0,0,0,     0,1,32'hDEAD, 0,0,     0,N,0));
    vecs.push_back(mk(1,0,0,0,     1,0,0,        0,0,     0,N,0));
    vecs.push_back(mk(0,0,0,0,     1,0,0,        1,0,     0,N,0));
    vecs.push_back(mk(0,0,0,0,     1,1,dimg(0),  1,1,     0,N,0));
    vecs.push_back(mk(0,1,0,0,     1,1,dimg(1),  0,2,     1,dimg(0),0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,1,0,0,   1,0,0,        0,2,     1,dimg(0),0));
    vecs.push_back(mk(0,0,0,0,     1,0,0,        0,2,     1,dimg(0),0));
    vecs.push_back(mk(0,0,0,0,     1,0,0,        1,2,     1,dimg(1),1));
    vecs.push_back(mk(0,0,0,0,     1,1,dimg(2),  1,3,     0,N,0));
    vecs.push_back(mk(0,0,0,0,     1,1,dimg(3),  0,4,     1,dimg(2),2));
    vecs.push_back(mk(0,0,0,0,     1,0,0,        1,4,     1,dimg(3),3));
    vecs.push_back(mk(0,0,0,0,     1,0,0,        1,5,     0,N,0));
    vecs.push_back(mk(0,0,1,'h40,  0,0,0,        0,6,     0,N,0));
    vecs.push_back(mk(0,0,0,0,     1,1,dimg(4),  1,'h40,  0,N,0));
    vecs.push_back(mk(0,0,0,0,     1,1,dimg(5),  1,'h41,  0,N,0));
    vecs.push_back(mk(0,0,0,0,     1,1,dimg('h40), 0,'h42, 0,N,0));
    vecs.push_back(mk(0,0,0,0,     1,1,dimg('h41), 0,'h42, 1,dimg('h40),'h40));
    vecs.push_back(mk(0,1,1,6,     0,0,0,        1,'h42,  1,dimg('h41),'h41));
    vecs.push_back(mk(0,0,0,0,     1,0,0,        1,6,     0,N,0));
    vecs.push_back(mk(0,0,1,'h80,  1,1,dimg(6),  1,7,     0,N,0));
    vecs.push_back(mk(0,0,0,0,     1,1,dimg(7),  1,'h80,  0,N,0));
    vecs.push_back(mk(0,0,0,0,     0,1,dimg('h80), 1,'h81, 0,N,0));
    vecs.push_back(mk(0,0,0,0,     0,0,0,        1,'h81,  1,dimg('h80),'h80));
    vecs.push_back(mk(0,0,0,0,     0,1,32'hBAD,  1,'h81,  0,N,0));
    vecs.push_back(mk(0,0,0,0,     1,0,0,        1,'h81,  0,N,0));
    vecs.push_back(mk(0,0,0,0,     1,1,dimg('h81), 1,'h82, 0,N,0));
    vecs.push_back(mk(0,1,0,0,     1,1,dimg('h82), 0,'h83, 1,dimg('h81),'h81));
    vecs.push_back(mk(0,1,0,0,     0,0,0,        0,'h83,  1,dimg('h81),'h81));

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out", 98'({a_req, a_addr, a_valid, a_data, a_pc}),
        98'({1'b0, 32'h0, 1'b0, N, 32'h0}));
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      a_start = vecs[i].start; a_stall = vecs[i].stall;
      a_redir = vecs[i].redir; a_rpc   = vecs[i].rpc;
      a_ack   = vecs[i].ack;   a_rv    = vecs[i].rv;
      a_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("vec%0d", i),
          98'({a_req, a_addr, a_valid, a_data, a_pc}),
          98'({vecs[i].req, vecs[i].addr, vecs[i].valid,
               vecs[i].data, vecs[i].pc}));
    end

    @(negedge clk);
    #2;
    chk("full_before_rst", 98'({a_valid, a_pc}), 98'({1'b1, 32'h81}));
    rst = 1'b1;
    #1;
    chk("async_rst_req", 98'(a_req), 98'(1'b0));
    chk("async_rst_valid", 98'(a_valid), 98'(1'b0));
    chk("async_rst_data", 98'(a_data), 98'(N));
    chk("async_rst_pc", 98'({a_pc, a_addr}), 98'({32'h0, 32'h0}));

    @(negedge clk);
    rst = 1'b0; a_stall = 0; a_ack = 1;
    a_rv = 1; a_rdata = 32'hBEEF;
    #1;
    chk("idle_rv0", 98'({a_req, a_valid}), 98'(2'b00));
    @(negedge clk);
    #1;
    chk("idle_rv1", 98'({a_req, a_valid}), 98'(2'b00));
    @(negedge clk);
    a_rv = 0; a_start = 1;
    @(negedge clk);
    a_start = 0;
    #1;
    chk("restart", 98'({a_req, a_addr, a_valid}),
        98'({1'b1, 32'h0, 1'b0}));

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 0;
    step4(0, 1, 0);
    step4(0, 0, 0);
    step4(0, 0, 0);
    for (int i = 0; i < 4; i++) step4(0, 0, 1);
    chk("zw_count", 98'(pops), 98'(4));
    for (int i = 0; i < 3000; i++) step4(1, 0, -1);
    chk("progress", 98'(pops > 300), 98'(1'b1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
